multi_delay_timer: RTL and testbench
====================================

// Module: multi_delay_timer
// PURPOSE
//  NCH independent programmable delay/interval timers sharing one clock.
//  Each channel counts ticks to a run-time-loaded terminal value and emits a 1-cycle sig pulse.
//  Each channel runs in PERIODIC or ONESHOT mode and flags overrun when its period shrinks below the live count.
//  Replaces fixed-constant delay counters in the timing subsystem.
// PARAMETERS
//  NCH        4       number of channels (1..16)
//  CBITS      19      counter / period width
//  DEFAULT_N  400000  per-channel period after reset (must fit CBITS)
//  PRESCALE   8       tick divider, used only with DELAY_PRESCALE_EN (>=1)
// PORTS
//  clk         in   1              clock, all logic posedge
//  rst         in   1              synchronous reset, active-high
//  start       in   NCH            per-channel arm pulse
//  stop        in   NCH            per-channel disarm pulse
//  wr_en       in   1              config write strobe
//  wr_ch       in   $clog2(NCH)    config target channel
//  wr_period   in   CBITS          new terminal count N
//  wr_mode     in   1              0=PERIODIC, 1=ONESHOT
//  err_clr     in   NCH            clear sticky err
//  sig         out  NCH            1-cycle expiry pulse (registered)
//  flg         out  NCH            channel active and cnt<=N
//  err         out  NCH            sticky overrun flag
// BEHAVIOUR
//  Reset (rst=1 at edge): cnt=0, active=0, sig=0, flg=0, err=0, period=DEFAULT_N, mode=PERIODIC for all channels.
//  Tick: every cycle; with DELAY_PRESCALE_EN, one cycle in PRESCALE.
//  Counting: while active, each tick cnt<=cnt+1; at tick where cnt==N: cnt<=0, sig<=1 for exactly one clk cycle.
//   Interval = N+1 ticks; N=0 in PERIODIC gives sig every tick.
//  PERIODIC: stays active after expiry. ONESHOT: active<=0 on expiry, cnt holds 0.
//  start[i]: active<=1, cnt<=0 (restart if already active, no sig). stop[i]: active<=0, cnt<=0, no sig.
//   start and stop in the same cycle: stop wins.
//  Config write: period/mode of wr_ch updated at edge, effective next cycle. Channel state otherwise unchanged.
//   If active and new N < current cnt: err<=1 (sticky), cnt<=0, no sig.
//  start and wr_en to the same channel in one cycle: write applied, cnt<=0, no err.
//  err_clr[i]: err<=0 unless a new overrun sets it the same cycle (set wins).
//  flg[i] = active && cnt<=N (registered, same cycle as cnt).
//  cnt never exceeds N. Wrap is only via expiry/overrun, never via CBITS overflow.
//  sig is driven 0 when not active. rst mid-count aborts with no sig.
// CONFIGURATION
//  DELAY_PRESCALE_EN defined: shared free-running prescaler (width $clog2(PRESCALE)+1, reset 0).
//   Tick is asserted one cycle in PRESCALE. Interval becomes (N+1)*PRESCALE cycles.
//   sig stays 1 clk wide. start/stop/config take effect immediately, not on tick.
//  Undefined: tick=1 constantly and no prescaler logic is present.
// STRUCTURE
//  Package delay_pkg: mode_e {MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1}, default CBITS, DEFAULT_N.
//  Sub-module delay_channel: one channel's cnt/active/period/mode/err.
//   Top holds write decode, optional prescaler, and a generate loop over NCH.
// TESTING
//  1. rst, CBITS=8, ch0 N=4 PERIODIC, start[0] -> sig[0] high 5 cycles after start, then every 5 cycles. flg[0]=1 throughout.
//  2. ch1 N=3 ONESHOT, start -> single sig at +4. active/flg drop the cycle after. No further sig for 20 cycles.
//  3. ch0 N=10, at cnt=7 write N=5 -> err[0]=1 next cycle, cnt=0, no sig. err_clr[0] -> err=0. Next sig 6 cycles later.
//  4. N=0 PERIODIC -> sig every cycle. stop and start in the same cycle -> channel idle, sig=0.
//  5. rst at cnt=N-1 -> no sig, all outputs 0, period back to DEFAULT_N. Channels independent: ch2 N=2 unaffected by ch3 traffic.
//  6. DELAY_PRESCALE_EN, PRESCALE=4, N=2 -> sig every 12 cycles, 1 cycle wide.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and default sizing for the multi-channel delay timer.
package delay_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int DEF_CBITS = 19;
    localparam int DEF_N     = 400000;

endpackage

// File: rtl/delay_channel.sv
// One timer channel: counter, arm state, period/mode config and sticky overrun flag.
module delay_channel
    import delay_pkg::*;
#(
    parameter int CBITS     = DEF_CBITS,
    parameter int DEFAULT_N = DEF_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             wr_i,
    input  logic [CBITS-1:0] wr_period_i,
    input  mode_e            wr_mode_i,
    input  logic             err_clr_i,
    output logic             sig_o,
    output logic             flg_o,
    output logic             err_o
);

    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] period_q, period_d;
    mode_e            mode_q, mode_d;
    logic             active_q, active_d;
    logic             sig_q, sig_d;
    logic             flg_q, flg_d;
    logic             err_q, err_d;
    logic             err_set;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        active_d = active_q;
        sig_d    = 1'b0;
        err_set  = 1'b0;

        if (wr_i) begin
            period_d = wr_period_i;
            mode_d   = wr_mode_i;
        end

        if (stop_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (wr_i && (wr_period_i < cnt_q)) begin
                err_set = 1'b1;
                cnt_d   = '0;
            // A write landing exactly on the live count expires now so cnt never passes N.
            end else if (tick_i) begin
                if ((cnt_q == period_q) || (wr_i && (cnt_q == wr_period_i))) begin
                    cnt_d = '0;
                    sig_d = 1'b1;
                    if (mode_q == MODE_ONESHOT) begin
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        flg_d = active_d && (cnt_d <= period_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= CBITS'(DEFAULT_N);
            mode_q   <= MODE_PERIODIC;
            active_q <= 1'b0;
            sig_q    <= 1'b0;
            flg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            active_q <= active_d;
            sig_q    <= sig_d;
            flg_q    <= flg_d;
            err_q    <= err_d;
        end
    end

    assign sig_o = sig_q;
    assign flg_o = flg_q;
    assign err_o = err_q;

endmodule

// File: rtl/multi_delay_timer.sv
// NCH programmable delay/interval timers with shared write decode and tick.
// Define DELAY_PRESCALE_EN to divide the tick by PRESCALE with a shared prescaler.
module multi_delay_timer
    import delay_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CBITS     = DEF_CBITS,
    parameter int DEFAULT_N = DEF_N,
    parameter int PRESCALE  = 8,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [CBITS-1:0] wr_period,
    input  logic             wr_mode,
    input  logic [NCH-1:0]   err_clr,
    output logic [NCH-1:0]   sig,
    output logic [NCH-1:0]   flg,
    output logic [NCH-1:0]   err
);

    logic           tick;
    logic [NCH-1:0] wr_sel;

    if ((NCH < 1) || (NCH > 16) || (PRESCALE < 1) || ((DEFAULT_N >> CBITS) != 0)) begin : g_param_check
        $error("multi_delay_timer: illegal parameter combination");
    end

`ifdef DELAY_PRESCALE_EN
    localparam int PSW = $clog2(PRESCALE) + 1;

    logic [PSW-1:0] ps_q, ps_d;

    always_comb begin
        ps_d = (ps_q == PSW'(PRESCALE - 1)) ? '0 : ps_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign tick = (ps_q == PSW'(PRESCALE - 1));
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_sel[i] = wr_en && (wr_ch == CHW'(i));

        delay_channel #(
            .CBITS     (CBITS),
            .DEFAULT_N (DEFAULT_N)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick),
            .start_i     (start[i]),
            .stop_i      (stop[i]),
            .wr_i        (wr_sel[i]),
            .wr_period_i (wr_period),
            .wr_mode_i   (mode_e'(wr_mode)),
            .err_clr_i   (err_clr[i]),
            .sig_o       (sig[i]),
            .flg_o       (flg[i]),
            .err_o       (err[i])
        );
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Scoreboard bench for multi_delay_timer: expected sig pulse cycles are queued per channel.
module tb_multi_delay_timer;
    import delay_pkg::*;

    localparam int NCH       = 4;
    localparam int CBITS     = 8;
    localparam int DEFAULT_N = 20;
    localparam int PRESCALE  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   start, stop, err_clr;
    logic             wr_en;
    logic [1:0]       wr_ch;
    logic [CBITS-1:0] wr_period;
    logic             wr_mode;
    logic [NCH-1:0]   sig, flg, err;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[NCH][$];

    multi_delay_timer #(
        .NCH       (NCH),
        .CBITS     (CBITS),
        .DEFAULT_N (DEFAULT_N),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
        .wr_mode   (wr_mode),
        .err_clr   (err_clr),
        .sig       (sig),
        .flg       (flg),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every sig pulse must match the head of its channel's queue.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL sig%0d_missing: no pulse seen, required at cycle %0d (now %0d)", ch, exp_q[ch][0], cyc);
                void'(exp_q[ch].pop_front());
            end
            if (sig[ch]) begin
                n_tests++;
                if (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc) begin
                    void'(exp_q[ch].pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL sig%0d_unexpected: pulse at cycle %0d, next required %0d", ch, cyc,
                             (exp_q[ch].size() > 0) ? exp_q[ch][0] : -1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int ch, input int n, input mode_e m);
        wr_en     = 1'b1;
        wr_ch     = ch[1:0];
        wr_period = n[CBITS-1:0];
        wr_mode   = m;
        step();
        wr_en     = 1'b0;
    endtask

    task automatic pulse_start(input int ch);
        start[ch] = 1'b1;
        step();
        start = '0;
    endtask

    task automatic pulse_stop(input int ch);
        stop[ch] = 1'b1;
        step();
        stop = '0;
    endtask

    initial begin
        int c;
        int c2;
        rst = 1'b1; start = '0; stop = '0; err_clr = '0;
        wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_mode = 1'b0;
        repeat (3) step();
        check("reset_sig", int'(sig), 0);
        check("reset_flg", int'(flg), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        step();

`ifndef DELAY_PRESCALE_EN
        // Periodic N=4: first pulse 5 cycles after start edge, then every 5.
        wr(0, 4, MODE_PERIODIC);
        c = cyc;
        for (int j = 0; j < 4; j++) exp_q[0].push_back(c + 6 + 5 * j);
        pulse_start(0);
        while (cyc < c + 22) begin
            check("t1_flg0", int'(flg[0]), 1);
            step();
        end
        pulse_stop(0);
        check("t1_flg0_after_stop", int'(flg[0]), 0);

        // One-shot N=3: single pulse, disarmed on expiry.
        wr(1, 3, MODE_ONESHOT);
        c = cyc;
        exp_q[1].push_back(c + 5);
        pulse_start(1);
        check("t2_flg1_armed", int'(flg[1]), 1);
        wait_until(c + 4);
        check("t2_flg1_last", int'(flg[1]), 1);
        wait_until(c + 5);
        check("t2_flg1_disarmed", int'(flg[1]), 0);
        wait_until(c + 25);

        // Overrun: shrink N from 10 to 5 while cnt=7.
        wr(0, 10, MODE_PERIODIC);
        c = cyc;
        pulse_start(0);
        wait_until(c + 8);
        exp_q[0].push_back(c + 15);
        exp_q[0].push_back(c + 21);
        wr(0, 5, MODE_PERIODIC);
        check("t3_err0_set", int'(err[0]), 1);
        check("t3_sig0_none", int'(sig[0]), 0);
        check("t3_flg0", int'(flg[0]), 1);
        err_clr[0] = 1'b1;
        step();
        err_clr = '0;
        check("t3_err0_clr", int'(err[0]), 0);
        wait_until(c + 23);
        pulse_stop(0);

        // N=0 periodic: pulse every cycle; start+stop together leaves it idle.
        wr(2, 0, MODE_PERIODIC);
        c = cyc;
        for (int j = 2; j <= 6; j++) exp_q[2].push_back(c + j);
        pulse_start(2);
        wait_until(c + 6);
        start[2] = 1'b1;
        stop[2]  = 1'b1;
        step();
        start = '0;
        stop  = '0;
        check("t4_flg2_idle", int'(flg[2]), 0);
        check("t4_sig2_idle", int'(sig[2]), 0);
        wait_until(c + 12);

        // Independence of ch2 from ch3 traffic, then reset at cnt=N-1.
        wr(2, 2, MODE_PERIODIC);
        c = cyc;
        for (int j = 0; j < 4; j++) exp_q[2].push_back(c + 4 + 3 * j);
        pulse_start(2);
        wr(3, 5, MODE_ONESHOT);
        exp_q[3].push_back(c + 9);
        pulse_start(3);
        wait_until(c + 14);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_sig", int'(sig), 0);
        check("t5_rst_flg", int'(flg), 0);
        check("t5_rst_err", int'(err), 0);
        wait_until(c + 20);
        // ch1 was one-shot N=3; after reset it must be periodic N=DEFAULT_N.
        c2 = cyc;
        exp_q[1].push_back(c2 + DEFAULT_N + 2);
        exp_q[1].push_back(c2 + 2 * DEFAULT_N + 3);
        pulse_start(1);
        wait_until(c2 + 2 * DEFAULT_N + 4);
        check("t5_flg1_periodic", int'(flg[1]), 1);
        pulse_stop(1);
`else
        // Prescaled tick: ticks land on edges r+4k after the last reset edge r.
        begin
            int r, s, t, first;
            rst = 1'b1;
            step();
            r = cyc;
            rst = 1'b0;
            wr(0, 2, MODE_PERIODIC);
            s = cyc + 1;
            t = s + 1;
            while (((t - r) % PRESCALE) != 0) t++;
            first = t + PRESCALE * 2;
            for (int j = 0; j < 3; j++) exp_q[0].push_back(first + 3 * PRESCALE * j);
            pulse_start(0);
            check("t6_flg0", int'(flg[0]), 1);
            wait_until(first + 6 * PRESCALE + 1);
            pulse_stop(0);
            check("t6_flg0_stopped", int'(flg[0]), 0);
        end
`endif

        repeat (4) step();
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("pending_sig%0d", ch), exp_q[ch].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
